// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// default frame width and the bit-counter width helper.
package fifo_uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // A 1-bit frame still needs a 1-bit counter to keep the vector legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake, frame configuration and serial line of the
// transmitter; master is the transmitter, slave is the FIFO/line side.
interface fifo_uart_tx_if
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  R_EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  R_INC;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        input  R_EMPTY,
        input  RD_DATA,
        input  PAR_EN,
        input  PAR_TYP,
        output R_INC,
        output TX_OUT,
        output BUSY
    );

    modport slave (
        output R_EMPTY,
        output RD_DATA,
        output PAR_EN,
        output PAR_TYP,
        input  R_INC,
        input  TX_OUT,
        input  BUSY
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for the latched frame word: even parity by default, odd when
// par_typ is set.
module uart_tx_parity_calc
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO read port and serialises them
// as start / data (LSB first) / optional parity / stop, one bit per clock.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// START  | start bit (0) on the line
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit of the latched word
// STOP   | stop bit (1); pops the next word here for back-to-back frames
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    fifo_uart_tx_if.master bus
);

    localparam int                CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  r_inc;
    logic                  parity_bit;

    // Pop is gated by reset so nothing is consumed while the block is held.
    assign r_inc = RST && !bus.R_EMPTY && ((state_q == IDLE) || (state_q == STOP));

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (parity_bit)
    );

    // tx_d is the line level for the state being entered, so TX_OUT is a
    // flop that lines up with state_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (r_inc) begin
                    data_d    = bus.RD_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = data_q[0];
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    tx_d  = data_q[cnt_d];
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (r_inc) begin
                    data_d    = bus.RD_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    state_d   = START;
                    tx_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
        end
    end

    assign bus.R_INC  = r_inc;
    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = (state_q != IDLE);

endmodule
